// File: rtl/conv_encoder_tx.sv
// rtl/conv_encoder_tx.sv - rate-1/2 K=3 convolutional encoder emitting one frame as a symbol stream
module conv_encoder_tx #(
    parameter int             FRAME_BITS = 62,
    parameter int             K          = 3,
    parameter logic [K-1:0]   G0         = 3'b111,
    parameter logic [K-1:0]   G1         = 3'b101
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_input,
    input  logic [FRAME_BITS-1:0] data_in,
    output logic                  ready,
    output logic [1:0]            data_out,
    output logic                  valid_output,
    input  logic                  sym_ready,
    output logic                  last,
    output logic                  done,
    output logic [9:0]            sym_cnt
);

    localparam logic [9:0] LAST_PAY = 10'(FRAME_BITS - 1);
    localparam logic [9:0] LAST_IDX = 10'(FRAME_BITS + K - 2);

    typedef enum logic [1:0] {IDLE, ENCODE, TAIL} fsm_t;

    fsm_t                  fsm, fsm_next;
    logic [FRAME_BITS-1:0] frame;
    logic [K-2:0]          enc_state;
    logic                  load;
    logic                  accept;
    logic                  next_bit;

    // Window is {u, s1, s2, ...}; generator MSB taps the current input bit.
    function automatic logic [1:0] enc_sym(input logic u, input logic [K-2:0] s);
        logic [K-1:0] w;
        w = {u, s};
        return {^(w & G0), ^(w & G1)};
    endfunction

    function automatic logic [K-2:0] shift_state(input logic u, input logic [K-2:0] s);
        logic [K-1:0] w;
        w = {u, s};
        return w[K-1:1];
    endfunction

    assign ready    = (fsm == IDLE);
    assign load     = valid_input & ready;
    assign accept   = valid_output & sym_ready;
    // Zeros shift in behind the payload, so the tail bits fall out for free.
    assign next_bit = frame[FRAME_BITS-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (load) fsm_next = ENCODE;
            ENCODE:  if (accept && sym_cnt == LAST_PAY) fsm_next = TAIL;
            TAIL:    if (accept && sym_cnt == LAST_IDX) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame        <= '0;
            enc_state    <= '0;
            data_out     <= 2'b00;
            valid_output <= 1'b0;
            last         <= 1'b0;
            done         <= 1'b0;
            sym_cnt      <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                frame        <= {data_in[FRAME_BITS-2:0], 1'b0};
                enc_state    <= shift_state(data_in[FRAME_BITS-1], '0);
                data_out     <= enc_sym(data_in[FRAME_BITS-1], '0);
                valid_output <= 1'b1;
                last         <= 1'b0;
                sym_cnt      <= '0;
            end else if (accept) begin
                if (sym_cnt == LAST_IDX) begin
                    valid_output <= 1'b0;
                    last         <= 1'b0;
                    done         <= 1'b1;
                    sym_cnt      <= '0;
                end else begin
                    frame     <= {frame[FRAME_BITS-2:0], 1'b0};
                    enc_state <= shift_state(next_bit, enc_state);
                    data_out  <= enc_sym(next_bit, enc_state);
                    last      <= (sym_cnt + 10'd1 == LAST_IDX);
                    sym_cnt   <= sym_cnt + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb/tb_conv_encoder_tx.sv - scoreboard bench for conv_encoder_tx
module tb_conv_encoder_tx;

    localparam int FB   = 62;
    localparam int NSYM = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_input = 1'b0;
    logic [FB-1:0] data_in = '0;
    logic          sym_ready = 1'b1;
    logic          ready;
    logic [1:0]    data_out;
    logic          valid_output;
    logic          last;
    logic          done;
    logic [9:0]    sym_cnt;

    conv_encoder_tx dut (
        .clk(clk), .reset(rst), .valid_input(valid_input), .data_in(data_in),
        .ready(ready), .data_out(data_out), .valid_output(valid_output),
        .sym_ready(sym_ready), .last(last), .done(done), .sym_cnt(sym_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       lst;
        logic [9:0] idx;
        logic [1:0] sym;
    } exp_t;

    exp_t       q[$];
    logic [1:0] cap[5];
    logic       capture = 1'b0;
    logic       stalled = 1'b0;
    logic [1:0] hold_d;
    logic [9:0] hold_c;
    logic       hold_l;
    int         done_pend = 0;
    exp_t       e;

    task automatic push_frame(input logic [FB-1:0] d);
        logic s1, s2, u;
        exp_t x;
        s1 = 1'b0;
        s2 = 1'b0;
        for (int i = 0; i < NSYM; i++) begin
            u     = (i < FB) ? d[FB-1-i] : 1'b0;
            x.sym = {u ^ s1 ^ s2, u ^ s2};
            x.idx = 10'(i);
            x.lst = (i == NSYM - 1);
            q.push_back(x);
            s2 = s1;
            s1 = u;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stalled   = 1'b0;
            done_pend = 0;
        end else begin
            if (done_pend == 1) begin
                check("done_pulse", 32'(done), 32'd1);
                check("ready_after_done", 32'(ready), 32'd1);
                check("valid_after_done", 32'(valid_output), 32'd0);
                check("cnt_after_done", 32'(sym_cnt), 32'd0);
                done_pend = 2;
            end else if (done_pend == 2) begin
                check("done_clears", 32'(done), 32'd0);
                done_pend = 0;
            end
            if (stalled) begin
                check("stall_data", 32'(data_out), 32'(hold_d));
                check("stall_cnt", 32'(sym_cnt), 32'(hold_c));
                check("stall_last", 32'(last), 32'(hold_l));
            end
            stalled = 1'b0;
            if (valid_output) begin
                if (sym_ready) begin
                    if (q.size() == 0) begin
                        check("extra_symbol", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        check("sym", 32'(data_out), 32'(e.sym));
                        check("sym_cnt", 32'(sym_cnt), 32'(e.idx));
                        check("last", 32'(last), 32'(e.lst));
                        check("ready_busy", 32'(ready), 32'd0);
                        if (capture && e.idx < 10'd5) cap[e.idx[2:0]] = data_out;
                        if (e.lst) done_pend = 1;
                    end
                end else begin
                    stalled = 1'b1;
                    hold_d  = data_out;
                    hold_c  = sym_cnt;
                    hold_l  = last;
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic run_frame(input logic [FB-1:0] d, input logic bp, input logic pulse);
        int n;
        wait_ready();
        push_frame(d);
        valid_input = 1'b1;
        data_in     = d;
        @(posedge clk); #1;
        valid_input = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            sym_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pulse && n == 10) begin
                valid_input = 1'b1;
                data_in     = ~d;
            end else begin
                valid_input = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        valid_input = 1'b0;
        check("frame_timeout", 32'(q.size()), 32'd0);
        sym_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0]   r;
        logic [FB-1:0] d;
        int            n;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_valid", 32'(valid_output), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(sym_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame('0, 1'b0, 1'b0);

        capture = 1'b1;
        d = '0;
        d[FB-1] = 1'b1;
        run_frame(d, 1'b0, 1'b0);
        check("imp0", 32'(cap[0]), 32'h3);
        check("imp1", 32'(cap[1]), 32'h2);
        check("imp2", 32'(cap[2]), 32'h3);
        check("imp3", 32'(cap[3]), 32'h0);

        r = {$urandom(), $urandom()};
        d = {5'b10011, r[56:0]};
        run_frame(d, 1'b0, 1'b0);
        check("vit0", 32'(cap[0]), 32'h3);
        check("vit1", 32'(cap[1]), 32'h2);
        check("vit2", 32'(cap[2]), 32'h3);
        check("vit3", 32'(cap[3]), 32'h3);
        check("vit4", 32'(cap[4]), 32'h1);
        capture = 1'b0;

        run_frame(d, 1'b1, 1'b0);
        run_frame('0, 1'b1, 1'b0);

        r = {$urandom(), $urandom()};
        run_frame(r[FB-1:0], 1'b0, 1'b1);

        wait_ready();
        r = {$urandom(), $urandom()};
        push_frame(r[FB-1:0]);
        valid_input = 1'b1;
        data_in     = r[FB-1:0];
        @(posedge clk); #1;
        valid_input = 1'b0;
        n = 0;
        while (sym_cnt != 10'd20 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_cnt20", 32'(sym_cnt), 32'd20);
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_data", 32'(data_out), 32'd0);
        check("abort_valid", 32'(valid_output), 32'd0);
        check("abort_last", 32'(last), 32'd0);
        check("abort_cnt", 32'(sym_cnt), 32'd0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        r = {$urandom(), $urandom()};
        run_frame(r[FB-1:0], 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
